// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the bit-serial adder/subtractor.
// Optional signed-overflow output is enabled by defining SERIAL_ADDER_OVF_EN.
package serial_adder_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // A single-beat configuration still needs a 1-bit counter.
   function automatic int cnt_width(input int nbeats);
      return (nbeats <= 1) ? 1 : $clog2(nbeats);
   endfunction

endpackage

// File: rtl/fa_bit.sv
// Combinational 1-bit full adder; the unit cell chained inside serial_adder_sub.
module fa_bit (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);

   assign sum  = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder_sub.sv
// Bit-serial WIDTH-bit adder/subtractor processing BITS_PER_CYCLE bits per beat.
// Define SERIAL_ADDER_OVF_EN to add the registered signed-overflow output ovf.
module serial_adder_sub
   import serial_adder_pkg::*;
#(
   parameter int WIDTH          = 8,
   parameter int BITS_PER_CYCLE = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int NBEATS = (BITS_PER_CYCLE > 0) ? WIDTH / BITS_PER_CYCLE : 1;
   localparam int CW     = cnt_width(NBEATS);

   generate
      if (WIDTH < 1 || BITS_PER_CYCLE < 1 || (WIDTH % BITS_PER_CYCLE) != 0) begin : g_bad_cfg
         $error("serial_adder_sub: BITS_PER_CYCLE must divide WIDTH exactly");
      end
   endgenerate

   state_t                    state;
   state_t                    state_next;
   logic [WIDTH-1:0]          a_sh;
   logic [WIDTH-1:0]          b_sh;
   logic                      carry;
   logic [CW-1:0]             beat;
   logic [BITS_PER_CYCLE:0]   c;
   logic [BITS_PER_CYCLE-1:0] s;
   logic [WIDTH-1:0]          beat_ext;
   logic                      last_beat;

   // Ripple chain for one beat; c[0] is the carry held over from the previous beat.
   assign c[0] = carry;

   generate
      for (genvar i = 0; i < BITS_PER_CYCLE; i++) begin : g_chain
         fa_bit u_fa (
            .a    (a_sh[i]),
            .b    (b_sh[i]),
            .cin  (c[i]),
            .sum  (s[i]),
            .cout (c[i+1])
         );
      end
   endgenerate

   assign last_beat = (beat == CW'(NBEATS - 1));

   // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
   always_comb begin
      beat_ext                      = '0;
      beat_ext[BITS_PER_CYCLE-1:0]  = s;
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      unique case (state)
         IDLE:    if (in_valid)  state_next = RUN;
         RUN:     if (last_beat) state_next = DONE;
         DONE:    if (out_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state == IDLE);
      out_valid = (state == DONE);
   end

   // Subtraction is folded in at load time: B is inverted and the borrow-in becomes carry-in.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sh  <= '0;
         b_sh  <= '0;
         carry <= 1'b0;
         beat  <= '0;
         sum   <= '0;
         cout  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
         ovf   <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_sh  <= a;
                  b_sh  <= b ^ {WIDTH{sub}};
                  carry <= cin ^ sub;
                  beat  <= '0;
                  sum   <= '0;
               end
            end
            RUN: begin
               a_sh  <= a_sh >> BITS_PER_CYCLE;
               b_sh  <= b_sh >> BITS_PER_CYCLE;
               sum   <= (sum >> BITS_PER_CYCLE) | (beat_ext << (WIDTH - BITS_PER_CYCLE));
               carry <= c[BITS_PER_CYCLE];
               beat  <= beat + 1'b1;
               if (last_beat) begin
                  cout <= c[BITS_PER_CYCLE];
`ifdef SERIAL_ADDER_OVF_EN
                  ovf  <= c[BITS_PER_CYCLE-1] ^ c[BITS_PER_CYCLE];
`endif
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_adder_sub.sv
// Directed self-checking bench for serial_adder_sub (8/1, 16/4 and 8/8 configurations).
// Overflow checks run only when SERIAL_ADDER_OVF_EN is defined.
module tb_serial_adder_sub;

   logic clk = 1'b0;
   logic rst_n;
   int   n_checks = 0;
   int   n_pass   = 0;

   always #5 clk = ~clk;

   // WIDTH=8, BITS_PER_CYCLE=1
   logic [7:0] a0, b0, sum0;
   logic       cin0, sub0, iv0, ir0, ov0, or0, cout0;
   // WIDTH=16, BITS_PER_CYCLE=4
   logic [15:0] a1, b1, sum1;
   logic        cin1, sub1, iv1, ir1, ov1, or1, cout1;
   // WIDTH=8, BITS_PER_CYCLE=8
   logic [7:0] a2, b2, sum2;
   logic       cin2, sub2, iv2, ir2, ov2, or2, cout2;
`ifdef SERIAL_ADDER_OVF_EN
   logic ovf0, ovf1, ovf2;
`endif

   serial_adder_sub #(.WIDTH(8), .BITS_PER_CYCLE(1)) u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(iv0), .in_ready(ir0), .a(a0), .b(b0),
      .cin(cin0), .sub(sub0), .out_valid(ov0), .out_ready(or0), .sum(sum0), .cout(cout0)
`ifdef SERIAL_ADDER_OVF_EN
      , .ovf(ovf0)
`endif
   );

   serial_adder_sub #(.WIDTH(16), .BITS_PER_CYCLE(4)) u_dut_w16 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1),
      .cin(cin1), .sub(sub1), .out_valid(ov1), .out_ready(or1), .sum(sum1), .cout(cout1)
`ifdef SERIAL_ADDER_OVF_EN
      , .ovf(ovf1)
`endif
   );

   serial_adder_sub #(.WIDTH(8), .BITS_PER_CYCLE(8)) u_dut_par (
      .clk(clk), .rst_n(rst_n), .in_valid(iv2), .in_ready(ir2), .a(a2), .b(b2),
      .cin(cin2), .sub(sub2), .out_valid(ov2), .out_ready(or2), .sum(sum2), .cout(cout2)
`ifdef SERIAL_ADDER_OVF_EN
      , .ovf(ovf2)
`endif
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      else n_pass++;
   endtask

   // Launch one operation on the 8/1 instance; returns cycles from the accepting edge to out_valid.
   task automatic do_op(input logic [7:0] ta, input logic [7:0] tb_v, input logic tci,
                        input logic tsub, output int lat);
      int ir_bad;
      @(negedge clk);
      check("idle_in_ready", ir0, 1'b1);
      a0 = ta; b0 = tb_v; cin0 = tci; sub0 = tsub; iv0 = 1'b1;
      @(posedge clk); #1;
      iv0 = 1'b0; a0 = 8'($urandom); b0 = 8'($urandom); cin0 = ~tci; sub0 = ~tsub;
      lat = 0; ir_bad = 0;
      while (!ov0 && lat < 40) begin
         if (ir0) ir_bad++;
         @(posedge clk); #1; lat++;
      end
      check("busy_in_ready_low", ir_bad, 0);
   endtask

   task automatic finish_op;
      or0 = 1'b1;
      @(posedge clk); #1;
      or0 = 1'b0;
      check("handshake_out_valid", ov0, 1'b0);
      check("handshake_in_ready", ir0, 1'b1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      int bad;
      logic [7:0] held_sum;
      logic       held_cout;

      rst_n = 1'b0;
      {a0, b0, cin0, sub0, iv0, or0} = '0;
      {a1, b1, cin1, sub1, iv1, or1} = '0;
      {a2, b2, cin2, sub2, iv2, or2} = '0;
      #12;
      check("rst_in_ready", ir0, 1'b1);
      check("rst_out_valid", ov0, 1'b0);
      check("rst_sum", sum0, 8'h00);
      check("rst_cout", cout0, 1'b0);
      @(negedge clk); rst_n = 1'b1;

      // Add with carry-in
      do_op(8'h5A, 8'hA5, 1'b1, 1'b0, lat);
      check("add_latency", lat, 8);
      check("add_sum", sum0, 8'h00);
      check("add_cout", cout0, 1'b1);
      finish_op();
      check("sum_held_after_handshake", sum0, 8'h00);

      do_op(8'h12, 8'h34, 1'b0, 1'b0, lat);
      check("add2_sum", sum0, 8'h46);
      check("add2_cout", cout0, 1'b0);
      finish_op();

      // Subtract, no borrow / with borrow / with borrow-in
      do_op(8'h10, 8'h01, 1'b0, 1'b1, lat);
      check("sub_sum", sum0, 8'h0F);
      check("sub_cout", cout0, 1'b1);
      finish_op();

      do_op(8'h00, 8'h01, 1'b0, 1'b1, lat);
      check("sub_borrow_sum", sum0, 8'hFF);
      check("sub_borrow_cout", cout0, 1'b0);
      finish_op();

      do_op(8'h10, 8'h01, 1'b1, 1'b1, lat);
      check("sub_bin_sum", sum0, 8'h0E);
      check("sub_bin_cout", cout0, 1'b1);
      finish_op();

`ifdef SERIAL_ADDER_OVF_EN
      do_op(8'h7F, 8'h01, 1'b0, 1'b0, lat);
      check("ovf_add_sum", sum0, 8'h80);
      check("ovf_add_flag", ovf0, 1'b1);
      finish_op();
      do_op(8'h80, 8'h01, 1'b0, 1'b1, lat);
      check("ovf_sub_sum", sum0, 8'h7F);
      check("ovf_sub_flag", ovf0, 1'b1);
      finish_op();
      do_op(8'h01, 8'h01, 1'b0, 1'b0, lat);
      check("no_ovf_sum", sum0, 8'h02);
      check("no_ovf_flag", ovf0, 1'b0);
      finish_op();
`endif

      // Backpressure: DONE held for 5 cycles while new operands are offered
      do_op(8'hC3, 8'h3C, 1'b0, 1'b0, lat);
      check("bp_sum", sum0, 8'hFF);
      held_sum = sum0; held_cout = cout0; bad = 0;
      a0 = 8'h11; b0 = 8'h22; iv0 = 1'b1;
      repeat (5) begin
         @(posedge clk); #1;
         if (!ov0 || ir0 || sum0 !== held_sum || cout0 !== held_cout) bad++;
      end
      check("bp_stable", bad, 0);
      iv0 = 1'b0;
      finish_op();
      check("bp_sum_after", sum0, 8'hFF);

      // Spacing from handshake to the next result with operands ready immediately
      a0 = 8'hFF; b0 = 8'h04; cin0 = 1'b0; sub0 = 1'b0; iv0 = 1'b1;
      @(posedge clk); #1;
      iv0 = 1'b0;
      lat = 1;
      while (!ov0 && lat < 40) begin
         @(posedge clk); #1; lat++;
      end
      check("b2b_spacing", lat, 9);
      check("b2b_sum", sum0, 8'h03);
      check("b2b_cout", cout0, 1'b1);
      finish_op();

      // Asynchronous reset during beat 3
      @(negedge clk);
      a0 = 8'hFF; b0 = 8'h00; cin0 = 1'b0; sub0 = 1'b0; iv0 = 1'b1;
      @(posedge clk); #1;
      iv0 = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("mid_run_partial_sum", sum0, 8'hE0);
      rst_n = 1'b0;
      #1;
      check("abort_out_valid", ov0, 1'b0);
      check("abort_sum", sum0, 8'h00);
      check("abort_cout", cout0, 1'b0);
      check("abort_in_ready", ir0, 1'b1);
      @(negedge clk); rst_n = 1'b1;
      do_op(8'h5A, 8'h25, 1'b0, 1'b0, lat);
      check("post_abort_latency", lat, 8);
      check("post_abort_sum", sum0, 8'h7F);
      finish_op();

      // WIDTH=16, 4 bits per beat
      @(negedge clk);
      a1 = 16'hFFFF; b1 = 16'h0001; cin1 = 1'b0; sub1 = 1'b0; iv1 = 1'b1;
      @(posedge clk); #1;
      iv1 = 1'b0;
      lat = 0;
      while (!ov1 && lat < 40) begin
         @(posedge clk); #1; lat++;
      end
      check("w16_latency", lat, 4);
      check("w16_sum", sum1, 16'h0000);
      check("w16_cout", cout1, 1'b1);
      or1 = 1'b1; @(posedge clk); #1; or1 = 1'b0;
      check("w16_in_ready", ir1, 1'b1);

      // WIDTH=8, whole word in one beat
      @(negedge clk);
      a2 = 8'hC8; b2 = 8'h64; cin2 = 1'b0; sub2 = 1'b0; iv2 = 1'b1;
      @(posedge clk); #1;
      iv2 = 1'b0;
      lat = 0;
      while (!ov2 && lat < 40) begin
         @(posedge clk); #1; lat++;
      end
      check("par_latency", lat, 1);
      check("par_sum", sum2, 8'h2C);
      check("par_cout", cout2, 1'b1);
      or2 = 1'b1; @(posedge clk); #1; or2 = 1'b0;

      @(negedge clk);
      a2 = 8'h05; b2 = 8'h07; cin2 = 1'b0; sub2 = 1'b1; iv2 = 1'b1;
      @(posedge clk); #1;
      iv2 = 1'b0;
      lat = 0;
      while (!ov2 && lat < 40) begin
         @(posedge clk); #1; lat++;
      end
      check("par_sub_sum", sum2, 8'hFE);
      check("par_sub_cout", cout2, 1'b0);
      or2 = 1'b1; @(posedge clk); #1; or2 = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
